// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, null flit constant and the
// destination-field extractor used by both the ingress FIFO and the router.
package noc_pkg;

    localparam int unsigned FLIT_W   = 20;
    localparam int unsigned DEST_LSB = 12;
    localparam int unsigned DEST_W   = 4;

    typedef logic [FLIT_W-1:0] flit_t;

    localparam flit_t NULL_FLIT = '0;

    function automatic logic [DEST_W-1:0] flit_dest(input flit_t f);
        return f[DEST_LSB +: DEST_W];
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x W register file for the ingress FIFO.
// Ports:
//   clk   - write clock (rising edge)
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address (asynchronous read)
//   rdata - mem[raddr]
// Storage is deliberately not reset.
module sync_fifo_ram #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned W     = 20
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/flit_ingress_fifo.sv
// Ingress buffer behind the ROM traffic injector. Filters null words, queues
// flits in a first-word-fall-through FIFO and hands them to the router on a
// valid/ready handshake with the destination field pre-extracted.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_data, in_valid   - injector stream (cannot be stalled)
//   out_data, out_dest  - head flit and its destination field
//   out_valid, out_ready- router handshake
//   count, full         - occupancy 0..DEPTH, count==DEPTH
//   overflow            - sticky: a non-null word was dropped on full
//   rx_cnt, drop_cnt    - saturating stored / dropped flit counters
module flit_ingress_fifo
    import noc_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AW        = 3,
    parameter bit          DROP_NULL = 1'b1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] in_data,
    input  logic              in_valid,
    output logic [FLIT_W-1:0] out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW:0]       count,
    output logic              full,
    output logic              overflow,
    output logic [CNT_W-1:0]  rx_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [AW:0]      count_q;
    logic [CNT_W-1:0] rx_cnt_q, drop_cnt_q;
    logic             overflow_q;

    logic is_null, cand, pop, push, drop;

    assign out_valid = (count_q != '0);
    assign full      = (count_q == (AW+1)'(DEPTH));

    assign is_null = (in_data == NULL_FLIT);
    assign cand    = in_valid & ~(DROP_NULL & is_null);
    assign pop     = out_valid & out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push    = cand & (~full | pop);
    assign drop    = cand & full & ~pop;

    sync_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (FLIT_W)
    ) u_ram (
        .clk   (clk),
        .we    (push & ~rst),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (out_data)
    );

    assign out_dest = flit_dest(out_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rx_cnt_q   <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (push && (rx_cnt_q != '1)) begin
                rx_cnt_q <= rx_cnt_q + 1'b1;
            end
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign rx_cnt   = rx_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule
